// File: rtl/subset_pkg.sv
// Shared encodings and default geometry for the subset search pipeline controller.
// Command codes, controller states and the update-command predicate live here.
package subset_pkg;

  localparam int DEF_NUM_GROUPS = 5;
  localparam int DEF_NUM_STAGES = 10;
  localparam int DEF_TUPLE_W    = 104;
  localparam int DEF_INDEX_W    = 11;
  localparam int DEF_RULEID_W   = 11;

  typedef enum logic [1:0] {
    CMD_SEARCH = 2'b00,
    CMD_INSERT = 2'b01,
    CMD_DELETE = 2'b10,
    CMD_NOP    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DRAIN    = 2'b01,
    ST_UPD_WAIT = 2'b10
  } state_e;

  function automatic logic is_update(input logic [1:0] cmd);
    return (cmd == CMD_INSERT) || (cmd == CMD_DELETE);
  endfunction

endpackage

// File: rtl/subset_pipe_ctrl_if.sv
// Request channel into the controller: valid/ready handshake plus command,
// header, segment size and per-group starting indices.
interface subset_pipe_ctrl_if #(
  parameter int TUPLE_W    = 104,
  parameter int NUM_GROUPS = 5,
  parameter int INDEX_W    = 11
) ();

  logic                          in_valid;
  logic                          in_ready;
  logic [1:0]                    command;
  logic [TUPLE_W-1:0]            tupleData;
  logic                          smallorbig_segment;
  logic [NUM_GROUPS*INDEX_W-1:0] start_index;

  modport master (
    output in_valid, command, tupleData, smallorbig_segment, start_index,
    input  in_ready
  );

  modport slave (
    input  in_valid, command, tupleData, smallorbig_segment, start_index,
    output in_ready
  );

endinterface

// File: rtl/subset_prio_reduce.sv
// Combinational priority reduce: picks the lowest rule ID among the valid
// candidates. Lower ID means higher priority; with no valid candidate the ID is 0.
module subset_prio_reduce #(
  parameter int NUM_CAND = 6,
  parameter int RULEID_W = 11
) (
  input  logic [NUM_CAND-1:0]          cand_valid,
  input  logic [NUM_CAND*RULEID_W-1:0] cand_id,
  output logic                         best_valid,
  output logic [RULEID_W-1:0]          best_id
);

  always_comb begin
    best_valid = 1'b0;
    best_id    = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cand_valid[i] &&
          (!best_valid || (cand_id[i*RULEID_W +: RULEID_W] < best_id))) begin
        best_valid = 1'b1;
        best_id    = cand_id[i*RULEID_W +: RULEID_W];
      end
    end
  end

endmodule

// File: rtl/subset_pipe_ctrl.sv
// Search pipeline controller: carries searches through NUM_STAGES slots merging
// per-stage group hits into a best rule ID, and serialises table updates.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// IDLE     | accepting searches every cycle, updates and nops
// DRAIN    | update pending, holding off input until all slots are empty
// UPD_WAIT | update request issued, waiting for the writer's upd_done
module subset_pipe_ctrl
  import subset_pkg::*;
#(
  parameter int NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int TUPLE_W    = DEF_TUPLE_W,
  parameter int INDEX_W    = DEF_INDEX_W,
  parameter int RULEID_W   = DEF_RULEID_W
) (
  input  logic                                     clk,
  input  logic                                     rst,
  subset_pipe_ctrl_if.slave                        req,
  output logic [NUM_STAGES*NUM_GROUPS*INDEX_W-1:0]  search_index,
  input  logic [NUM_STAGES*NUM_GROUPS-1:0]          stage_match,
  input  logic [NUM_STAGES*NUM_GROUPS*RULEID_W-1:0] stage_ruleID,
  output logic                                     upd_req,
  output logic [1:0]                               upd_cmd,
  output logic [TUPLE_W-1:0]                       upd_tuple,
  input  logic                                     upd_done,
  output logic                                     out_valid,
  output logic                                     match,
  output logic [RULEID_W-1:0]                      match_ruleID
);

  localparam logic [NUM_GROUPS-1:0] GRP0_MASK = NUM_GROUPS'(1);

  state_e state, state_nxt;

  logic accept;
  logic accept_search;
  logic accept_update;
  logic pipe_busy;
  logic upd_issue;

  // Slot contents. The header itself is not kept: downstream stages are
  // addressed purely through search_index.
  logic [NUM_STAGES-1:0]         slot_valid;
  logic [NUM_GROUPS-1:0]         slot_mask [NUM_STAGES];
  logic [NUM_GROUPS*INDEX_W-1:0] slot_index [NUM_STAGES];
  logic [NUM_STAGES-1:0]         slot_best_valid;
  logic [RULEID_W-1:0]           slot_best_id [NUM_STAGES];

  logic [NUM_STAGES-1:0]         red_valid;
  logic [RULEID_W-1:0]           red_id [NUM_STAGES];

  assign req.in_ready  = (state == ST_IDLE);
  assign accept        = req.in_valid && req.in_ready;
  assign accept_search = accept && (req.command == CMD_SEARCH);
  assign accept_update = accept && is_update(req.command);
  assign pipe_busy     = |slot_valid;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    logic [NUM_GROUPS:0]                cand_valid;
    logic [(NUM_GROUPS+1)*RULEID_W-1:0] cand_id;

    // Hits only count for active groups of an occupied slot.
    assign cand_valid = {slot_best_valid[s],
                         stage_match[s*NUM_GROUPS +: NUM_GROUPS] & slot_mask[s]}
                        & {(NUM_GROUPS+1){slot_valid[s]}};
    assign cand_id    = {slot_best_id[s],
                         stage_ruleID[s*NUM_GROUPS*RULEID_W +: NUM_GROUPS*RULEID_W]};

    subset_prio_reduce #(
      .NUM_CAND (NUM_GROUPS + 1),
      .RULEID_W (RULEID_W)
    ) u_reduce (
      .cand_valid (cand_valid),
      .cand_id    (cand_id),
      .best_valid (red_valid[s]),
      .best_id    (red_id[s])
    );

    assign search_index[s*NUM_GROUPS*INDEX_W +: NUM_GROUPS*INDEX_W] = slot_index[s];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        slot_valid[s]      <= 1'b0;
        slot_mask[s]       <= '0;
        slot_index[s]      <= '0;
        slot_best_valid[s] <= 1'b0;
        slot_best_id[s]    <= '0;
      end
      out_valid    <= 1'b0;
      match        <= 1'b0;
      match_ruleID <= '0;
    end else begin
      slot_valid[0]      <= accept_search;
      slot_mask[0]       <= accept_search ? (req.smallorbig_segment ? '1 : GRP0_MASK) : '0;
      slot_index[0]      <= accept_search ? req.start_index : '0;
      slot_best_valid[0] <= 1'b0;
      slot_best_id[0]    <= '0;
      for (int s = 1; s < NUM_STAGES; s++) begin
        slot_valid[s]      <= slot_valid[s-1];
        slot_mask[s]       <= slot_mask[s-1];
        slot_index[s]      <= slot_index[s-1];
        slot_best_valid[s] <= red_valid[s-1];
        slot_best_id[s]    <= red_id[s-1];
      end
      out_valid    <= slot_valid[NUM_STAGES-1];
      match        <= red_valid[NUM_STAGES-1];
      match_ruleID <= red_valid[NUM_STAGES-1] ? red_id[NUM_STAGES-1] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An update arriving with an empty pipeline skips DRAIN so the writer
  // request goes out on the very next cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept_update) begin
          state_nxt = pipe_busy ? ST_DRAIN : ST_UPD_WAIT;
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy) begin
          state_nxt = ST_UPD_WAIT;
        end
      end
      ST_UPD_WAIT: begin
        if (upd_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign upd_issue = (state_nxt == ST_UPD_WAIT) && (state != ST_UPD_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_req   <= 1'b0;
      upd_cmd   <= '0;
      upd_tuple <= '0;
    end else begin
      upd_req <= upd_issue;
      if (accept_update) begin
        upd_cmd   <= req.command;
        upd_tuple <= req.tupleData;
      end
    end
  end

endmodule

// File: tb/tb_subset_pipe_ctrl.sv
// Directed bench for subset_pipe_ctrl; the search-stage responder answers per
// stage/group from a hit table keyed by the packet number encoded in search_index.
module tb_subset_pipe_ctrl;
  import subset_pkg::*;

  localparam int G = 5;
  localparam int S = 10;
  localparam int TW = 104;
  localparam int IW = 11;
  localparam int RW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [S*G*IW-1:0] search_index;
  logic [S*G-1:0]    stage_match;
  logic [S*G*RW-1:0] stage_ruleID;
  logic              upd_req;
  logic [1:0]        upd_cmd;
  logic [TW-1:0]     upd_tuple;
  logic              upd_done = 1'b0;
  logic              out_valid;
  logic              match;
  logic [RW-1:0]     match_ruleID;

  int nvec = 0;
  int nerr = 0;

  bit            hit_v  [16][S][G];
  logic [RW-1:0] hit_id [16][S][G];
  logic [IW-1:0] rsp_idx;

  subset_pipe_ctrl_if #(.TUPLE_W(TW), .NUM_GROUPS(G), .INDEX_W(IW)) rq ();

  subset_pipe_ctrl #(
    .NUM_GROUPS(G), .NUM_STAGES(S), .TUPLE_W(TW), .INDEX_W(IW), .RULEID_W(RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (rq),
    .search_index (search_index),
    .stage_match  (stage_match),
    .stage_ruleID (stage_ruleID),
    .upd_req      (upd_req),
    .upd_cmd      (upd_cmd),
    .upd_tuple    (upd_tuple),
    .upd_done     (upd_done),
    .out_valid    (out_valid),
    .match        (match),
    .match_ruleID (match_ruleID)
  );

  always #5 clk = ~clk;

  // Index layout per group: {packet[7:0], group[2:0]}.
  always_comb begin
    stage_match  = '0;
    stage_ruleID = '0;
    rsp_idx      = '0;
    for (int s = 0; s < S; s++) begin
      for (int g = 0; g < G; g++) begin
        rsp_idx = search_index[(s*G+g)*IW +: IW];
        if (rsp_idx[10:7] == 4'd0 && int'(rsp_idx[2:0]) == g && hit_v[rsp_idx[6:3]][s][g]) begin
          stage_match[s*G+g]           = 1'b1;
          stage_ruleID[(s*G+g)*RW +: RW] = hit_id[rsp_idx[6:3]][s][g];
        end
      end
    end
  end

  // Packet 0 is what empty slots present (index 0): it hits group 0 with ID 1
  // at every stage, so any leak from an empty slot corrupts results.
  task automatic clear_hits();
    for (int p = 0; p < 16; p++)
      for (int s = 0; s < S; s++)
        for (int g = 0; g < G; g++) begin
          hit_v[p][s][g]  = 1'b0;
          hit_id[p][s][g] = '0;
        end
    for (int s = 0; s < S; s++) begin
      hit_v[0][s][0]  = 1'b1;
      hit_id[0][s][0] = 11'd1;
    end
  endtask

  // Called just after a negedge; returns at the negedge after acceptance (cycle 1).
  task automatic send(input logic [1:0] cmd, input int pkt, input logic seg, input logic [TW-1:0] tup);
    logic [G*IW-1:0] si;
    int w;
    for (int g = 0; g < G; g++) si[g*IW +: IW] = IW'(pkt*8 + g);
    rq.in_valid = 1'b1;
    rq.command = cmd;
    rq.tupleData = tup;
    rq.smallorbig_segment = seg;
    rq.start_index = si;
    w = 0;
    while (!rq.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      nerr++;
      $display("FAIL send_accept: in_ready stuck at %0b, required 1", rq.in_ready);
    end
    @(negedge clk);
    rq.in_valid = 1'b0;
    rq.command = CMD_NOP;
    rq.start_index = '0;
  endtask

  task automatic test_reset();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    nvec++; if (match !== 1'b0) begin nerr++; $display("FAIL rst_match: got %0b want 0", match); end
    nvec++; if (match_ruleID !== '0) begin nerr++; $display("FAIL rst_ruleID: got %0d want 0", match_ruleID); end
    nvec++; if (upd_req !== 1'b0) begin nerr++; $display("FAIL rst_upd_req: got %0b want 0", upd_req); end
    nvec++; if (search_index !== '0) begin nerr++; $display("FAIL rst_search_index: got %0h want 0", search_index); end
    nvec++; if (rq.in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %0b want 1", rq.in_ready); end
  endtask

  task automatic test_search_vectors();
    int   pk [4]   = '{1, 2, 4, 5};
    logic sg [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic em [4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   eid [4]  = '{12, 0, 33, 2047};
    int   cnt;
    clear_hits();
    hit_v[1][3][2] = 1'b1; hit_id[1][3][2] = 11'd40;
    hit_v[1][7][0] = 1'b1; hit_id[1][7][0] = 11'd12;
    for (int s = 0; s < S; s++) begin
      hit_v[2][s][4] = 1'b1; hit_id[2][s][4] = 11'd5;
      hit_v[4][s][1] = 1'b1; hit_id[4][s][1] = 11'd2;
    end
    hit_v[4][0][0] = 1'b1; hit_id[4][0][0] = 11'd33;
    hit_v[4][9][0] = 1'b1; hit_id[4][9][0] = 11'd50;
    hit_v[5][9][4] = 1'b1; hit_id[5][9][4] = 11'd2047;
    for (int v = 0; v < 4; v++) begin
      send(CMD_SEARCH, pk[v], sg[v], TW'(pk[v]));
      cnt = 1;
      while (!out_valid && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      nvec++; if (cnt != 11) begin nerr++; $display("FAIL search%0d_latency: got %0d want 11", v, cnt); end
      nvec++; if (match !== em[v]) begin nerr++; $display("FAIL search%0d_match: got %0b want %0b", v, match, em[v]); end
      nvec++; if (match_ruleID !== RW'(eid[v])) begin nerr++; $display("FAIL search%0d_ruleID: got %0d want %0d", v, match_ruleID, eid[v]); end
      @(negedge clk);
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL search%0d_pulse_width: out_valid %0b want 0", v, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    clear_hits();
    for (int i = 0; i < 10; i++) begin
      hit_v[i+1][i%10][i%5]  = 1'b1;
      hit_id[i+1][i%10][i%5] = RW'(100 + i);
    end
    for (int i = 0; i < 10; i++) begin
      logic [G*IW-1:0] si;
      for (int g = 0; g < G; g++) si[g*IW +: IW] = IW'((i+1)*8 + g);
      nvec++; if (rq.in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready%0d: got %0b want 1", i, rq.in_ready); end
      rq.in_valid = 1'b1;
      rq.command = CMD_SEARCH;
      rq.smallorbig_segment = 1'b1;
      rq.start_index = si;
      @(negedge clk);
    end
    rq.in_valid = 1'b0;
    rq.command = CMD_NOP;
    rq.start_index = '0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL b2b_early: out_valid %0b want 0", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nvec++; if (out_valid !== 1'b1 || match !== 1'b1 || match_ruleID !== RW'(100 + i))
        begin nerr++; $display("FAIL b2b_out%0d: valid %0b match %0b id %0d want 1 1 %0d", i, out_valid, match, match_ruleID, 100 + i); end
    end
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL b2b_tail: out_valid %0b want 0", out_valid); end
  endtask

  task automatic test_update();
    logic [TW-1:0] tup = {13{8'hA5}};
    int out_cyc = 0, upd_cyc = 0, upd_cnt = 0, rdy_cyc = 0;
    clear_hits();
    send(CMD_SEARCH, 3, 1'b1, TW'(3));
    nvec++; if (rq.in_ready !== 1'b1) begin nerr++; $display("FAIL upd_ready_c1: got %0b want 1", rq.in_ready); end
    rq.in_valid = 1'b1;
    rq.command = CMD_INSERT;
    rq.tupleData = tup;
    @(negedge clk);
    rq.in_valid = 1'b0;
    rq.command = CMD_NOP;
    for (int cyc = 2; cyc <= 40; cyc++) begin
      if (out_valid && out_cyc == 0) out_cyc = cyc;
      if (upd_req) begin
        upd_cnt++;
        if (upd_cyc == 0) upd_cyc = cyc;
        nvec++; if (upd_cmd !== 2'b01) begin nerr++; $display("FAIL upd_cmd: got %0b want 01", upd_cmd); end
        nvec++; if (upd_tuple !== tup) begin nerr++; $display("FAIL upd_tuple: got %0h want %0h", upd_tuple, tup); end
      end
      if (rq.in_ready && rdy_cyc == 0) rdy_cyc = cyc;
      upd_done = (cyc == 5) || (upd_cyc != 0 && cyc == upd_cyc + 4);
      @(negedge clk);
    end
    upd_done = 1'b0;
    nvec++; if (out_cyc != 11) begin nerr++; $display("FAIL upd_search_out_cycle: got %0d want 11", out_cyc); end
    nvec++; if (upd_cnt != 1) begin nerr++; $display("FAIL upd_req_count: got %0d want 1", upd_cnt); end
    nvec++; if (upd_cyc != 12) begin nerr++; $display("FAIL upd_req_cycle: got %0d want 12", upd_cyc); end
    nvec++; if (rdy_cyc != 17) begin nerr++; $display("FAIL upd_ready_return: got %0d want 17", rdy_cyc); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    clear_hits();
    hit_v[3][2][0] = 1'b1; hit_id[3][2][0] = 11'd7;
    send(CMD_SEARCH, 3, 1'b1, TW'(3));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0 || match !== 1'b0 || match_ruleID !== '0)
      begin nerr++; $display("FAIL rstmid_result: valid %0b match %0b id %0d want 0 0 0", out_valid, match, match_ruleID); end
    nvec++; if (upd_req !== 1'b0 || upd_cmd !== 2'b00 || upd_tuple !== '0)
      begin nerr++; $display("FAIL rstmid_upd: req %0b cmd %0b tuple %0h want 0 0 0", upd_req, upd_cmd, upd_tuple); end
    nvec++; if (search_index !== '0) begin nerr++; $display("FAIL rstmid_search_index: got %0h want 0", search_index); end
    nvec++; if (rq.in_ready !== 1'b1) begin nerr++; $display("FAIL rstmid_ready: got %0b want 1", rq.in_ready); end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    nvec++; if (seen != 0) begin nerr++; $display("FAIL rstmid_ghost_out: %0d out_valid cycles want 0", seen); end
  endtask

  task automatic test_reset_upd();
    logic [TW-1:0] tup = {13{8'h3C}};
    int reqs = 0, busy = 0;
    clear_hits();
    send(CMD_DELETE, 6, 1'b1, tup);
    nvec++; if (upd_req !== 1'b1 || upd_cmd !== 2'b10 || upd_tuple !== tup)
      begin nerr++; $display("FAIL del_req: req %0b cmd %0b tuple %0h want 1 10 %0h", upd_req, upd_cmd, upd_tuple, tup); end
    nvec++; if (rq.in_ready !== 1'b0) begin nerr++; $display("FAIL del_ready: got %0b want 0", rq.in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++; if (upd_req !== 1'b0 || rq.in_ready !== 1'b1)
      begin nerr++; $display("FAIL rstupd_state: req %0b ready %0b want 0 1", upd_req, rq.in_ready); end
    repeat (10) begin
      @(negedge clk);
      if (upd_req) reqs++;
      if (!rq.in_ready) busy++;
    end
    nvec++; if (reqs != 0 || busy != 0) begin nerr++; $display("FAIL rstupd_after: upd_req %0d busy %0d want 0 0", reqs, busy); end
  endtask

  task automatic test_stray_nop();
    int outs = 0, reqs = 0, busy = 0, idx = 0;
    clear_hits();
    upd_done = 1'b1;
    send(CMD_NOP, 9, 1'b1, TW'(9));
    upd_done = 1'b0;
    repeat (12) begin
      if (out_valid) outs++;
      if (upd_req) reqs++;
      if (!rq.in_ready) busy++;
      if (search_index != '0) idx++;
      @(negedge clk);
    end
    nvec++; if (outs != 0) begin nerr++; $display("FAIL nop_out_valid: %0d cycles want 0", outs); end
    nvec++; if (reqs != 0) begin nerr++; $display("FAIL nop_upd_req: %0d cycles want 0", reqs); end
    nvec++; if (busy != 0) begin nerr++; $display("FAIL nop_ready: %0d low cycles want 0", busy); end
    nvec++; if (idx != 0) begin nerr++; $display("FAIL nop_slot_loaded: %0d nonzero index cycles want 0", idx); end
  endtask

  initial begin
    rq.in_valid = 1'b0;
    rq.command = CMD_NOP;
    rq.tupleData = '0;
    rq.smallorbig_segment = 1'b0;
    rq.start_index = '0;
    clear_hits();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_search_vectors();
    test_back_to_back();
    test_update();
    test_reset_mid();
    test_reset_upd();
    test_stray_nop();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
